// File: rtl/sdr_port_arbiter_pkg.sv
// Shared types and default sizes for the SDRAM application-port arbiter.
package sdr_pkg;

  localparam int SDR_ADDR_W     = 22;
  localparam int SDR_DATA_W     = 16;
  localparam int SDR_BURST_LEN  = 8;
  localparam int SDR_STARVE_MAX = 4;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    RD_CMD    = 3'd2,
    RD_DATA   = 3'd3,
    WR_CMD    = 3'd4,
    WR_DATA   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/sdr_port_arbiter_if.sv
// Application-port bus between the arbiter (master) and the SDRAM controller (slave).
interface sdr_port_arbiter_if
  import sdr_pkg::*;
#(
  parameter int ADDR_W = SDR_ADDR_W,
  parameter int DATA_W = SDR_DATA_W
);

  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] wdata;
  logic              wr_next;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output rd_req, wr_req, addr, wdata,
    input  ack, wr_next, rd_data, rd_valid
  );

  modport slave (
    input  rd_req, wr_req, addr, wdata,
    output ack, wr_next, rd_data, rd_valid
  );

endinterface

// File: rtl/sdr_port_arbiter_starve_ctr.sv
// Host anti-starvation counter and the video/host priority decision.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic vid_req,
  input  logic host_req,
  input  logic vid_gnt,
  input  logic host_gnt,
  output logic pick_host
);

  localparam int               CNT_W   = $clog2(STARVE_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;
  logic             starved_s;

  // Count video grants made while the host waits; a host grant or an uncontended video grant restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (host_gnt) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (vid_gnt) begin
      if (!host_req) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (starve_cnt_r != CNT_MAX) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Host wins when video is not asking or when the host has used up its waiting quota.
  always_comb begin
    starved_s = (starve_cnt_r == CNT_MAX);
    pick_host = host_req & (starved_s | ~vid_req);
  end

endmodule

// File: rtl/sdr_port_arbiter.sv
// Shares one SDRAM application port between the video reader and the host writer,
// one fixed-length burst per grant.
module sdr_port_arbiter
  import sdr_pkg::*;
#(
  parameter int ADDR_W     = SDR_ADDR_W,
  parameter int DATA_W     = SDR_DATA_W,
  parameter int BURST_LEN  = SDR_BURST_LEN,
  parameter int STARVE_MAX = SDR_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sdr_init_done,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_gnt,
  output logic [DATA_W-1:0]   vid_rdata,
  output logic                vid_rvalid,
  input  logic                host_req,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_gnt,
  output logic                host_wnext,
  sdr_port_arbiter_if.master  app,
  output logic                err_stray
);

  localparam int                BEAT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(BURST_LEN - 1));

  arb_state_t        state_r;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic              app_rd_req_r;
  logic              app_wr_req_r;
  logic [ADDR_W-1:0] app_addr_r;
  logic [DATA_W-1:0] vid_rdata_r;
  logic              vid_rvalid_r;
  logic              err_stray_r;
  logic              pick_host_s;
  logic              in_rd_data_s;
  logic              in_wr_data_s;
  logic              stray_s;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .host_req  (host_req),
    .vid_gnt   (vid_gnt),
    .host_gnt  (host_gnt),
    .pick_host (pick_host_s)
  );

  // Grants, write-data steering and stray detection are decoded from the current state.
  always_comb begin
    in_rd_data_s = (state_r == RD_DATA);
    in_wr_data_s = (state_r == WR_DATA);
    vid_gnt      = (state_r == RD_CMD) & app.ack;
    host_gnt     = (state_r == WR_CMD) & app.ack;
    host_wnext   = in_wr_data_s & app.wr_next;
    stray_s      = (app.rd_valid & ~in_rd_data_s) | (app.wr_next & ~in_wr_data_s);
    if (in_wr_data_s) begin
      app.wdata = host_wdata;
    end else begin
      app.wdata = {DATA_W{1'b0}};
    end
  end

  // Main sequencer: arbitration, command handshake and beat counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= WAIT_INIT;
      beat_cnt_r   <= {BEAT_W{1'b0}};
      app_rd_req_r <= 1'b0;
      app_wr_req_r <= 1'b0;
      app_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        WAIT_INIT: begin
          if (sdr_init_done) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          if (pick_host_s) begin
            state_r      <= WR_CMD;
            app_wr_req_r <= 1'b1;
            app_addr_r   <= host_addr & ADDR_MASK;
          end else if (vid_req) begin
            state_r      <= RD_CMD;
            app_rd_req_r <= 1'b1;
            app_addr_r   <= vid_addr & ADDR_MASK;
          end
        end
        RD_CMD: begin
          if (app.ack) begin
            state_r      <= RD_DATA;
            app_rd_req_r <= 1'b0;
            beat_cnt_r   <= {BEAT_W{1'b0}};
          end
        end
        RD_DATA: begin
          if (app.rd_valid) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            if (beat_cnt_r == LAST_BEAT) begin
              state_r <= IDLE;
            end
          end
        end
        WR_CMD: begin
          if (app.ack) begin
            state_r      <= WR_DATA;
            app_wr_req_r <= 1'b0;
            beat_cnt_r   <= {BEAT_W{1'b0}};
          end
        end
        WR_DATA: begin
          if (app.wr_next) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            if (beat_cnt_r == LAST_BEAT) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r      <= WAIT_INIT;
          app_rd_req_r <= 1'b0;
          app_wr_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Read data is re-timed one stage toward video; beats outside a read burst are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_rdata_r  <= {DATA_W{1'b0}};
      vid_rvalid_r <= 1'b0;
    end else if (app.rd_valid & in_rd_data_s) begin
      vid_rdata_r  <= app.rd_data;
      vid_rvalid_r <= 1'b1;
    end else begin
      vid_rdata_r  <= vid_rdata_r;
      vid_rvalid_r <= 1'b0;
    end
  end

  // Sticky flag for controller beats that arrive with no burst to absorb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_stray_r <= 1'b0;
    end else if (stray_s) begin
      err_stray_r <= 1'b1;
    end else begin
      err_stray_r <= err_stray_r;
    end
  end

  assign app.rd_req = app_rd_req_r;
  assign app.wr_req = app_wr_req_r;
  assign app.addr   = app_addr_r;
  assign vid_rdata  = vid_rdata_r;
  assign vid_rvalid = vid_rvalid_r;
  assign err_stray  = err_stray_r;

endmodule

// File: doc/sdr_port_arbiter.md
# sdr_port_arbiter

Two-requester arbiter and sequencer in front of the SDRAM controller's application port (`app_*`) for the mt48lc4m16a2 (4M x 16) framebuffer. It shares the single controller between the video line-fetch reader (priority, latency-critical) and the FTDI host writer, which streams pixel data into the framebuffer. It issues one fixed-length burst per grant, steers read data back to the video port and write data from the host port, and prevents the host from being starved.

## Interface
- `ADDR_W`, 22: word address width, 4M words.
- `DATA_W`, 16: SDRAM data width.
- `BURST_LEN`, 8: words per burst, power of two, 2..256.
- `STARVE_MAX`, 4: maximum consecutive video bursts granted while `host_req` is pending.

Ports:
- `clk`  in  1  SDRAM-domain clock. One clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sdr_init_done`  in  1  controller init complete; no request before it.
- `vid_req`  in  1  video burst request, held until `vid_gnt`.
- `vid_addr`  in  ADDR_W  video burst start address.
- `vid_gnt`  out  1  one-cycle pulse: video command accepted.
- `vid_rdata`  out  DATA_W  read word.
- `vid_rvalid`  out  1  `vid_rdata` valid.
- `host_req`  in  1  host burst request, held until `host_gnt`.
- `host_addr`  in  ADDR_W  host burst start address.
- `host_wdata`  in  DATA_W  current write word.
- `host_gnt`  out  1  one-cycle pulse: host command accepted.
- `host_wnext`  out  1  host must advance to the next word.
- `app_rd_req`, `app_wr_req`  out  1  controller command request, held until `app_ack`.
- `app_addr`  out  ADDR_W  command address.
- `app_ack`  in  1  command accepted.
- `app_wdata`  out  DATA_W  write word to the controller.
- `app_wr_next`  in  1  controller consumed `app_wdata`.
- `app_rd_data`  in  DATA_W  read word from the controller.
- `app_rd_valid`  in  1  `app_rd_data` valid.
- `err_stray`  out  1  sticky: `app_rd_valid` or `app_wr_next` seen outside a data phase.

## Operation
- FSM states: `WAIT_INIT`, `IDLE`, `RD_CMD`, `RD_DATA`, `WR_CMD`, `WR_DATA`. The reset state is `WAIT_INIT`.
- `WAIT_INIT` moves to `IDLE` on `sdr_init_done=1`. After that, `sdr_init_done` is ignored.
- Transitions out of `IDLE`:
  - If `host_req` is high and `starve_cnt==STARVE_MAX`, go to `WR_CMD`.
  - Otherwise, if `vid_req` is high, go to `RD_CMD`.
  - Otherwise, if `host_req` is high, go to `WR_CMD`.
  - Otherwise, stay in `IDLE`.
- `starve_cnt`:
  - +1, saturating, on each video grant while `host_req=1`.
  - Cleared on each host grant, and on a video grant while `host_req=0`.
- Address handling: `app_addr` is registered on `IDLE` exit. Its low log2(`BURST_LEN`) bits are forced to 0 (burst-aligned).
- `RD_CMD` / `WR_CMD`:
  - Assert `app_rd_req` / `app_wr_req` until `app_ack`.
  - In the ack cycle, pulse `vid_gnt` / `host_gnt`, clear `beat_cnt`, and go to `RD_DATA` / `WR_DATA`.
- `RD_DATA`:
  - Each `app_rd_valid` increments `beat_cnt`.
  - On the `BURST_LEN`-th beat, go to `IDLE`.
- `WR_DATA`:
  - `app_wdata = host_wdata` (combinational).
  - `host_wnext = app_wr_next`.
  - Each `app_wr_next` increments `beat_cnt`.
  - On the `BURST_LEN`-th beat, go to `IDLE`.
- Read steering: `vid_rdata` / `vid_rvalid` are `app_rd_data` / `app_rd_valid` registered one stage. `vid_rvalid` is gated to `RD_DATA`.
- Stray beats: `app_rd_valid` outside `RD_DATA`, or `app_wr_next` outside `WR_DATA`, is dropped and sets `err_stray`. Only reset clears it.
- Simultaneous `vid_req` and `host_req` in `IDLE`: video wins unless starvation triggers.
- Reset mid-burst: all state is cleared immediately and the FSM returns to `WAIT_INIT`. The partial burst is abandoned and the controller is reset by the same `reset_n`.

## Timing
- Reset values: `vid_gnt`, `vid_rvalid`, `host_gnt`, `host_wnext`, `app_rd_req`, `app_wr_req`, `err_stray` = 0. `app_addr`, `app_wdata`, `vid_rdata` = 0.
- Request to command: `vid_req` seen in `IDLE` at cycle N gives `app_rd_req=1` at N+1.
- Grant: `vid_gnt` is high in the same cycle as `app_ack`.
- Read data: `vid_rvalid` is 1 cycle after `app_rd_valid`.
- Write data: `host_wnext` has 0-cycle latency from `app_wr_next`.
- Turnaround: the cycle after the last beat is `IDLE`, and the next command can assert one cycle later. Minimum 2 idle-side cycles between bursts.
- Widths:
  - `beat_cnt` is log2(`BURST_LEN`)+1 bits.
  - `starve_cnt` is log2(`STARVE_MAX`)+1 bits and saturates; it never wraps.

## Structure
- Shared package `sdr_pkg`:
  - FSM state enum `arb_state_t`.
  - `SDR_ADDR_W=22`, `SDR_DATA_W=16`, default `BURST_LEN`.
- Sub-module `arb_starve_ctr`: the saturating counter plus the priority decision.
- The rest of the block is a single FSM/datapath module.

## Test plan
- Reset, then hold `sdr_init_done=0` with `vid_req=1`: no `app_rd_req` until init. When init rises at cycle T, `app_rd_req=1` at T+2.
- `vid_addr=0x1005`, ack after 3 cycles, 8 read beats of 0..7: `app_addr=0x1000`, one `vid_gnt` pulse, `vid_rdata` 0..7 each one cycle delayed, back to `IDLE` after beat 8.
- Host burst at `0x2000`, `app_wr_next` gapped (1,0,1,...): exactly 8 `host_wnext` pulses, `app_wdata` tracks `host_wdata`, a single `host_gnt`.
- `vid_req` and `host_req` both held high: grant order is V,V,V,V,H,V,V,V,V,H (`STARVE_MAX=4`).
- `app_rd_valid` pulsed while `IDLE`: `err_stray=1` and stays 1; `vid_rvalid` stays 0.
- `reset_n` low after beat 3 of a read: all outputs 0 asynchronously, FSM in `WAIT_INIT`, and a new burst completes normally after re-init.
